// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, TX FSM state codes, data-width limits.
// Also used by the future uart_rx; keep encodings stable.
package uart_pkg;

  typedef logic [1:0] par_mode_t;

  localparam par_mode_t PAR_NONE = 2'b00;
  localparam par_mode_t PAR_EVEN = 2'b01;
  localparam par_mode_t PAR_ODD  = 2'b10;

  localparam int DATA_W_MIN = 5;
  localparam int DATA_W_MAX = 9;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Caller zero-extends narrower characters; padding zeros do not change the XOR.
  function automatic logic parity_bit(input logic [DATA_W_MAX-1:0] d, input par_mode_t mode);
    return (^d) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Write-side and line-side signals of the configurable UART transmitter.
// master = upstream writer, slave = uart_tx_cfg.
interface uart_tx_cfg_if
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                          tx_start;
  logic [DATA_W-1:0]             tx_data;
  par_mode_t                     parity_mode;
  logic                          stop2;
  logic                          tx_ready;
  logic                          tx_overflow;
  logic                          tx_done;
  logic                          tx_busy;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;
  logic                          tx;

  modport master (
    output tx_start, tx_data, parity_mode, stop2,
    input  tx_ready, tx_overflow, tx_done, tx_busy, fifo_level, tx
  );

  modport slave (
    input  tx_start, tx_data, parity_mode, stop2,
    output tx_ready, tx_overflow, tx_done, tx_busy, fifo_level, tx
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with fall-through read data; push refused when full, pop ignored when empty.
// Fullness comes from registered level, so a push to a full FIFO is refused even on a pop cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("uart_sync_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];
  assign level    = level_q;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push_ok && !pop_ok) begin
      level_d = level_q + LW'(1);
    end else if (!push_ok && pop_ok) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter (DATA_W bits, none/even/odd parity, 1-2 stop bits) fed by a small FIFO.
// Push at edge N, pop at N+1, tx falls at N+2; writes refused with tx_overflow while the FIFO is full.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_cfg_if.slave  bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W_MAX + 1);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  if (CLKS_PER_BIT < 2) begin : g_chk_cpb
    $error("uart_tx_cfg: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_chk_data_w
    $error("uart_tx_cfg: DATA_W must be within 5..9");
  end

  logic              fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic [LW-1:0]     fifo_level;

  uart_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.tx_start),
    .push_data (bus.tx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              bit_last;

  assign bit_last = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = bit_last ? '0 : cnt_q + CW'(1);
    bit_d     = bit_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    done_d    = 1'b0;
    fifo_pop  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d    = '0;
        fifo_pop = !fifo_empty;
      end
      ST_START: begin
        if (bit_last) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_last) begin
          data_d = data_q >> 1;
          if (bit_q == BW'(DATA_W - 1)) begin
            bit_d   = '0;
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_last) begin
          state_d = ST_STOP;
          bit_d   = '0;
        end
      end
      ST_STOP: begin
        // bit_q tracks which stop bit is on the line when two are configured
        if (bit_last) begin
          if (stop2_q && bit_q == '0) begin
            bit_d = BW'(1);
          end else begin
            done_d   = 1'b1;
            fifo_pop = !fifo_empty;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line configuration is captured only here, so mid-frame changes wait for the next character.
    if (fifo_pop) begin
      state_d   = ST_START;
      cnt_d     = '0;
      bit_d     = '0;
      data_d    = fifo_dout;
      par_en_d  = (bus.parity_mode == PAR_EVEN) || (bus.parity_mode == PAR_ODD);
      par_bit_d = parity_bit(DATA_W_MAX'(fifo_dout), bus.parity_mode);
      stop2_d   = bus.stop2;
    end
  end

  always_comb begin
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_q[0];
      ST_PARITY: tx_d = par_bit_q;
      default:   tx_d = 1'b1;
    endcase
    ovf_d = bus.tx_start && fifo_full;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.tx          = tx_q;
  assign bus.tx_done     = done_q;
  assign bus.tx_overflow = ovf_q;
  assign bus.tx_ready    = !fifo_full;
  assign bus.tx_busy     = (state_q != ST_IDLE) || !fifo_empty;
  assign bus.fifo_level  = fifo_level;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: 8-bit and 7-bit instances at 16 clocks per bit.
// Frames are sampled every cycle and compared against hand-built bit patterns.
module tb_uart_tx_cfg;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic clk;
  logic reset;

  uart_tx_cfg_if #(.DATA_W(8), .FIFO_DEPTH(4)) bus8 ();
  uart_tx_cfg_if #(.DATA_W(7), .FIFO_DEPTH(4)) bus7 ();

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_W(8), .FIFO_DEPTH(4)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_W(7), .FIFO_DEPTH(4)) u_dut7 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus7.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic get_tx(input bit sel7);
    return sel7 ? bus7.tx : bus8.tx;
  endfunction

  function automatic logic get_done(input bit sel7);
    return sel7 ? bus7.tx_done : bus8.tx_done;
  endfunction

  // Running event counters for the 8-bit instance, sampled just after each edge.
  int ovf_tot = 0;
  int done_tot = 0;
  int low_tot = 0;
  int lvl_max = 0;
  always @(posedge clk) begin
    #1;
    if (bus8.tx_overflow === 1'b1) ovf_tot++;
    if (bus8.tx_done === 1'b1) done_tot++;
    if (bus8.tx === 1'b0) low_tot++;
    if (int'(bus8.fifo_level) > lvl_max) lvl_max = int'(bus8.fifo_level);
  end

  // Waits for the start bit, then records one frame; exp_bits[0] is the start bit.
  task automatic frame(input string tag, input bit sel7, input int nbits,
                       input logic [15:0] exp_bits, output int waited);
    logic [15:0] obs;
    logic        cur;
    int          bad, dn, dn_at, last;
    obs = '0; cur = 1'b1; bad = 0; dn = 0; dn_at = -1; waited = 0;
    last = nbits * CPB - 1;
    @(negedge clk);
    while (get_tx(sel7) !== 1'b0 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 1000) begin
      check({tag, "_start_timeout"}, 32'(get_tx(sel7)), 0);
      return;
    end
    for (int i = 0; i <= last; i++) begin
      if (i % CPB == 0) begin
        cur = get_tx(sel7);
        obs[i / CPB] = cur;
      end else if (get_tx(sel7) !== cur) begin
        bad++;
      end
      if (get_done(sel7) === 1'b1) begin
        dn++;
        dn_at = i;
      end
      if (i < last) @(negedge clk);
    end
    check({tag, "_bits"}, 32'(obs), 32'(exp_bits));
    check({tag, "_glitch"}, bad, 0);
    check({tag, "_done_at"}, dn_at, last);
    check({tag, "_done_n"}, dn, 1);
  endtask

  task automatic send8(input logic [7:0] d, input par_mode_t pm, input logic s2);
    @(negedge clk);
    bus8.tx_start = 1'b1;
    bus8.tx_data = d;
    bus8.parity_mode = pm;
    bus8.stop2 = s2;
    @(negedge clk);
    bus8.tx_start = 1'b0;
  endtask

  logic [7:0]  burst_dat [6] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
  logic [15:0] burst_exp [5] = '{16'h222, 16'h224, 16'h226, 16'h228, 16'h22A};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int ovf0, done0, low0;

    reset = 1'b1;
    bus8.tx_start = 1'b0; bus8.tx_data = '0; bus8.parity_mode = PAR_NONE; bus8.stop2 = 1'b0;
    bus7.tx_start = 1'b0; bus7.tx_data = '0; bus7.parity_mode = PAR_NONE; bus7.stop2 = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_tx",    32'(bus8.tx), 1);
    check("rst_busy",  32'(bus8.tx_busy), 0);
    check("rst_done",  32'(bus8.tx_done), 0);
    check("rst_ovf",   32'(bus8.tx_overflow), 0);
    check("rst_ready", 32'(bus8.tx_ready), 1);
    check("rst_level", 32'(bus8.fifo_level), 0);
    check("rst_tx7",   32'(bus7.tx), 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 8N1 0xA5; frame is 10 bits, tx_done in its 160th cycle
    send8(8'hA5, PAR_NONE, 1'b0);
    check("a5_level", 32'(bus8.fifo_level), 1);
    check("a5_tx_pre", 32'(bus8.tx), 1);
    frame("a5", 1'b0, 10, 16'h34A, w);
    check("a5_fall_lat", w, 1);
    @(negedge clk);
    check("a5_busy_after", 32'(bus8.tx_busy), 0);
    check("a5_level_after", 32'(bus8.fifo_level), 0);

    // Even then odd parity on 0x07 (three ones): parity bits 1 and 0
    send8(8'h07, PAR_EVEN, 1'b0);
    frame("even07", 1'b0, 11, 16'h60E, w);
    send8(8'h07, PAR_ODD, 1'b0);
    frame("odd07", 1'b0, 11, 16'h40E, w);

    // Two stop bits on 0x00; configuration changed after the pop must not matter
    send8(8'h00, PAR_NONE, 1'b1);
    @(negedge clk);
    bus8.stop2 = 1'b0;
    bus8.parity_mode = PAR_ODD;
    frame("stop2", 1'b0, 11, 16'h600, w);
    check("stop2_fall_lat", w, 0);
    bus8.parity_mode = PAR_NONE;
    repeat (3) @(negedge clk);

    // Six back-to-back writes: five queued, sixth overflows, frames abut
    ovf0 = ovf_tot;
    done0 = done_tot;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          if (i == 5) check("burst_full_ready", 32'(bus8.tx_ready), 0);
          bus8.tx_start = 1'b1;
          bus8.tx_data = burst_dat[i];
        end
        @(negedge clk);
        bus8.tx_start = 1'b0;
      end
      begin
        int wb;
        for (int j = 0; j < 5; j++) begin
          frame($sformatf("burst%0d", j), 1'b0, 10, burst_exp[j], wb);
          check($sformatf("burst%0d_gap", j), wb, (j == 0) ? 3 : 0);
        end
      end
    join
    check("burst_ovf_pulses", ovf_tot - ovf0, 1);
    check("burst_done_pulses", done_tot - done0, 5);
    check("burst_level_peak", lvl_max, 4);
    @(negedge clk);
    check("burst_busy_after", 32'(bus8.tx_busy), 0);
    check("burst_level_after", 32'(bus8.fifo_level), 0);

    // Reset during data bit 3 of 0xC3 with two characters still queued
    @(negedge clk);
    bus8.tx_start = 1'b1; bus8.tx_data = 8'hC3;
    @(negedge clk);
    bus8.tx_data = 8'h01;
    @(negedge clk);
    bus8.tx_data = 8'h02;
    @(negedge clk);
    bus8.tx_start = 1'b0;
    w = 0;
    while (bus8.tx !== 1'b0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    repeat (70) @(negedge clk);
    check("mid_rst_tx_pre", 32'(bus8.tx), 0);
    check("mid_rst_level_pre", 32'(bus8.fifo_level), 2);
    done0 = done_tot;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", 32'(bus8.tx), 1);
    check("mid_rst_busy", 32'(bus8.tx_busy), 0);
    check("mid_rst_level", 32'(bus8.fifo_level), 0);
    check("mid_rst_ready", 32'(bus8.tx_ready), 1);
    reset = 1'b0;
    low0 = low_tot;
    repeat (400) @(negedge clk);
    check("mid_rst_no_done", done_tot - done0, 0);
    check("mid_rst_line_high", low_tot - low0, 0);

    // 7-bit instance, odd parity, two stop bits, 0x55 (four ones -> parity 1)
    @(negedge clk);
    bus7.tx_start = 1'b1;
    bus7.tx_data = 7'h55;
    bus7.parity_mode = PAR_ODD;
    bus7.stop2 = 1'b1;
    @(negedge clk);
    bus7.tx_start = 1'b0;
    frame("w7_odd_s2", 1'b1, 11, 16'h7AA, w);
    @(negedge clk);
    check("w7_busy_after", 32'(bus7.tx_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised next-generation UART transmitter replacing the fixed 8N1 uart_tx.
- Adds configurable data width and a runtime-selectable parity mode (none/even/odd).
- Adds selectable 1 or 2 stop bits.
- Adds a small input FIFO so software/upstream logic can queue bytes and frames go out back-to-back.
- Sits between the system bus write path and the serial pin, single clock domain.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range is 2 or more.
- DATA_W, 8, data bits per frame; legal range 5..9.
- FIFO_DEPTH, 4, transmit FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- tx_start  in  1  write strobe; pushes tx_data into the FIFO when tx_ready=1.
- tx_data  in  DATA_W  character to queue.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- stop2  in  1  0 = one stop bit, 1 = two stop bits.
- tx_ready  out  1  FIFO not full.
- tx_overflow  out  1  one-cycle pulse when tx_start=1 and tx_ready=0; the data is dropped.
- tx_done  out  1  one-cycle pulse in the last cycle of each frame's final stop bit.
- tx_busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- tx  out  1  serial line; idles high.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: tx=1, tx_busy=0, tx_done=0, tx_overflow=0, tx_ready=1, fifo_level=0; FSM in IDLE; FIFO emptied.
- Reset mid-frame: tx returns to 1 at the next edge, the partial frame is abandoned, and no tx_done is issued.
- FIFO write rule: a push occurs only when tx_start=1 and the FIFO is not full. Fullness is evaluated before any same-cycle pop, so a write to a full FIFO is refused even if a pop happens that cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO leaves fifo_level unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if the FIFO is non-empty, pop the head, latch the data, latch parity_mode and stop2, and go to START. Configuration is sampled only at pop, so changes mid-frame have no effect.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: DATA_W bits, LSB first, each held CLKS_PER_BIT cycles. Then go to PARITY if the latched mode is even or odd, otherwise STOP.
  - PARITY: even mode sends the XOR of the data bits; odd mode sends its inverse. Held CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles, doubled if stop2 was latched.
    - In the final cycle: assert tx_done.
    - If the FIFO is non-empty, pop and enter START directly, giving zero idle cycles between frames.
    - Otherwise go to IDLE.
- Bit timing: the bit counter reloads on every state or bit change; every bit lasts exactly CLKS_PER_BIT cycles.
- Frame length is (1 + DATA_W + P + S) × CLKS_PER_BIT cycles, where P is 0 or 1 and S is 1 or 2.
- Latency: with an empty FIFO and FSM in IDLE, tx_start sampled at edge N gives a push at N and a pop at N+1; tx falls at edge N+2.
- tx is driven directly from a register, so the line is glitch-free.

Decomposition:
- Shared package uart_pkg holds:
  - parity_mode encodings PAR_NONE, PAR_EVEN, PAR_ODD;
  - the FSM state encoding;
  - the constants DATA_W_MIN=5 and DATA_W_MAX=9, with elaboration-time range checks.
- One natural sub-module: uart_sync_fifo (parameters WIDTH, DEPTH), a synchronous FIFO with full, empty and level outputs, reused later by uart_rx.
- The FSM, bit counter and parity logic stay in uart_tx_cfg.

Test Plan:
All scenarios use CLKS_PER_BIT=16, DATA_W=8, FIFO_DEPTH=4 unless stated.
- 8N1, 0xA5 queued once -> tx holds 0,1,0,1,0,0,1,0,1,1, each 16 cycles. tx_done pulses once, 160 cycles after the falling edge. tx_busy then drops, fifo_level=0.
- Even parity, 0x07 -> parity bit 1. Odd parity, 0x07 -> parity bit 0. Each frame is 176 cycles.
- stop2=1, 0x00 -> after the data bits, tx is high for 32 cycles before tx_done. Toggling stop2 mid-frame does not alter the frame.
- Six consecutive tx_start pulses from idle, data 0x11..0x16 -> five are accepted (the first pops immediately). The sixth gives one tx_overflow pulse and is dropped, with fifo_level peaking at 4. Five frames are sent with no idle gap: each start bit falls on the cycle after the previous tx_done. Five tx_done pulses in total.
- Reset asserted during data bit 3 of 0xC3 with 2 entries queued -> next edge: tx=1, tx_busy=0, fifo_level=0, tx_ready=1. No tx_done. Line stays high afterwards.
- DATA_W=7 instance, odd parity, stop2=1, data 0x55 -> tx holds 0,1,0,1,0,1,0,1,1,1,1 (start, 7 data bits, parity bit 1, then two stop bits), each 16 cycles.
